// File: rtl/spw_rx_data_in.sv
// Avalon-MM receive buffer for SpaceWire characters: codec pushes 9-bit chars, CPU pops via DATA.
// Optional EOP/EEP counter at address 3 is built when SPW_RX_EOP_COUNT_EN is defined.
module spw_rx_data_in #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [8:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [8:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              irq_q;

    logic rd, wr, empty, full, push, pop, flush, ovf_evt, ovf_clr;
    logic [15:0] count_ext;

    assign rd       = chipselect & ~read_n;
    assign wr       = chipselect & ~write_n;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign push     = in_valid & ~full;
    assign pop      = rd & (address == 2'd0) & ~empty;
    assign flush    = wr & (address == 2'd2) & writedata[31];
    assign ovf_evt  = in_valid & full;
    assign ovf_clr  = wr & (address == 2'd1) & writedata[2];
    assign in_ready = ~full;
    assign irq      = irq_q;
    assign count_ext = 16'(count_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ctrl_d   = ctrl_q;
        ovf_d    = (ovf_q & ~ovf_clr) | ovf_evt;
        if (wr && address == 2'd2) begin
            ctrl_d = writedata[1:0];
        end
        // Flush wins over any push/pop in the same cycle; overflow is left alone.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ctrl_q   <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= (ctrl_q[0] & ~empty) | (ctrl_q[1] & ovf_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef SPW_RX_EOP_COUNT_EN
    logic [15:0] eop_cnt_q;
    logic        eop_hit;

    assign eop_hit = push & ~flush & in_data[8] & (in_data[7:1] == 7'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop_cnt_q <= '0;
        end else if (wr && address == 2'd3) begin
            eop_cnt_q <= '0;
        end else if (eop_hit) begin
            eop_cnt_q <= eop_cnt_q + 16'd1;
        end
    end

    logic [28:0] unused_wdata;
    assign unused_wdata = {writedata[30:3], writedata[1:0] == 2'b00 ? 1'b0 : 1'b1};
`else
    logic [15:0] eop_cnt_q;
    assign eop_cnt_q = 16'd0;

    logic [27:0] unused_wdata;
    assign unused_wdata = writedata[30:3];
`endif

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: if (!empty) readdata = {1'b1, 22'd0, mem_q[rd_ptr_q]};
            2'd1: readdata = {16'd0, count_ext[7:0], 5'd0, ovf_q, full, empty};
            2'd2: readdata = {30'd0, ctrl_q};
            default: readdata = {16'd0, eop_cnt_q};
        endcase
    end

endmodule

// File: tb/tb_spw_rx_data_in.sv
// Directed self-checking bench for spw_rx_data_in (DEPTH=16).
module tb_spw_rx_data_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [8:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;

    spw_rx_data_in #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus/codec cycle; readdata is sampled before the active edge.
    task automatic cyc(input logic do_rd, input logic do_wr, input logic [1:0] a,
                       input logic [31:0] wd, input logic vld, input logic [8:0] din,
                       output logic [31:0] rdata);
        address    = a;
        chipselect = do_rd | do_wr;
        read_n     = ~do_rd;
        write_n    = ~do_wr;
        writedata  = wd;
        in_valid   = vld;
        in_data    = din;
        #1 rdata = readdata;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        in_valid   = 1'b0;
    endtask

    task automatic push(input logic [8:0] d);
        logic [31:0] x;
        cyc(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, d, x);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0, 9'd0, d);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] x;
        cyc(1'b0, 1'b1, a, d, 1'b0, 9'd0, x);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = 32'd0; in_data = 9'd0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        rd_reg(2'd1, rv); check("reset_status", rv, 32'h0000_0001);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rd_reg(2'd0, rv); check("reset_data", rv, 32'h0);

        push(9'h041); push(9'h042); push(9'h100);
        rd_reg(2'd1, rv); check("status_cnt3", rv, 32'h0000_0300);
        rd_reg(2'd0, rv); check("data0", rv, 32'h8000_0041);
        rd_reg(2'd0, rv); check("data1", rv, 32'h8000_0042);
        rd_reg(2'd0, rv); check("data2", rv, 32'h8000_0100);
        rd_reg(2'd0, rv); check("data_empty", rv, 32'h0000_0000);
        rd_reg(2'd1, rv); check("status_drained", rv, 32'h0000_0001);

        for (int i = 0; i < 15; i++) push(9'(i));
        check("in_ready_15", {31'd0, in_ready}, 32'd1);
        push(9'h0FF);
        check("in_ready_16", {31'd0, in_ready}, 32'd0);
        push(9'h0EE);
        rd_reg(2'd1, rv); check("status_ovf", rv, 32'h0000_1006);
        cyc(1'b0, 1'b1, 2'd1, 32'h4, 1'b1, 9'h0DD, rv);
        rd_reg(2'd1, rv); check("ovf_clr_vs_set", rv, 32'h0000_1006);
        wr_reg(2'd2, 32'h2);
        idle();
        check("irq_ovf", {31'd0, irq}, 32'd1);
        wr_reg(2'd1, 32'h4);
        idle();
        check("irq_ovf_clr", {31'd0, irq}, 32'd0);
        rd_reg(2'd1, rv); check("status_ovf_clr", rv, 32'h0000_1002);
        rd_reg(2'd0, rv); check("full_head", rv, 32'h8000_0000);
        wr_reg(2'd2, 32'h8000_0000);
        rd_reg(2'd1, rv); check("status_flush", rv, 32'h0000_0001);
        rd_reg(2'd2, rv); check("ctrl_flush_bit", rv, 32'h0);

        wr_reg(2'd2, 32'h1);
        idle();
        check("irq_empty", {31'd0, irq}, 32'd0);
        rd_reg(2'd2, rv); check("ctrl_rd", rv, 32'h1);
        push(9'h055);
        check("irq_lag", {31'd0, irq}, 32'd0);
        idle();
        check("irq_set", {31'd0, irq}, 32'd1);
        rd_reg(2'd0, rv); check("irq_pop_data", rv, 32'h8000_0055);
        check("irq_hold", {31'd0, irq}, 32'd1);
        idle();
        check("irq_clr", {31'd0, irq}, 32'd0);
        wr_reg(2'd2, 32'h0);

        for (int i = 0; i < 5; i++) push(9'h0A0 + 9'(i));
        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 9'h0A5, rv);
        check("simul_data", rv, 32'h8000_00A0);
        rd_reg(2'd1, rv); check("simul_cnt5", rv, 32'h0000_0500);
        for (int i = 1; i <= 5; i++) begin
            rd_reg(2'd0, rv); check("simul_order", rv, 32'h8000_00A0 + 32'(i));
        end
        rd_reg(2'd1, rv); check("simul_empty", rv, 32'h0000_0001);

        push(9'h011); push(9'h012); push(9'h013);
        cyc(1'b0, 1'b1, 2'd2, 32'h8000_0000, 1'b1, 9'h014, rv);
        rd_reg(2'd1, rv); check("flush_push_status", rv, 32'h0000_0001);
        rd_reg(2'd0, rv); check("flush_push_data", rv, 32'h0);

        cyc(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 9'h077, rv);
        check("push_on_empty_rd", rv, 32'h0);
        rd_reg(2'd1, rv); check("push_on_empty_cnt", rv, 32'h0000_0100);
        rd_reg(2'd0, rv); check("push_on_empty_data", rv, 32'h8000_0077);

`ifdef SPW_RX_EOP_COUNT_EN
        push(9'h100); push(9'h101); push(9'h102); push(9'h041);
        rd_reg(2'd3, rv); check("eop_cnt", rv, 32'd2);
        wr_reg(2'd3, 32'd0);
        rd_reg(2'd3, rv); check("eop_clr", rv, 32'd0);
        push(9'h101);
        cyc(1'b0, 1'b1, 2'd3, 32'd0, 1'b1, 9'h100, rv);
        rd_reg(2'd3, rv); check("eop_clr_vs_inc", rv, 32'd0);
        wr_reg(2'd2, 32'h8000_0000);
`else
        push(9'h100);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3, rv); check("addr3_zero", rv, 32'd0);
        wr_reg(2'd2, 32'h8000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
